// File: rtl/fifo_read_scheduler.sv
// fifo_read_scheduler
//   Read-side controller of the asynchronous FIFO, running in the r_clk domain.
//   Shares the single memory read port among N_REQ consumers with round-robin
//   arbitration and bounded bursts. Owns the binary/Gray read pointers, the
//   two-flop synchroniser for the incoming write-pointer Gray code, the
//   registered empty flag, and a flush that discards all unread contents.
//
// Ports
//   r_clk       read-domain clock
//   rst         asynchronous, active-low reset
//   req         per-consumer read request (level, held until served)
//   flush       single-cycle pulse, drops every word visible to the read side
//   w_ptr_gray  Gray-coded write pointer from the write clock domain
//   r_addr      memory read address (low ADDR_W bits of the binary pointer)
//   rd_en       combinational memory read strobe
//   gnt         combinational one-hot grant, zero whenever rd_en is low
//   rvalid      gnt delayed one cycle, aligned with registered memory data
//   r_ptr_gray  registered Gray read pointer for the write domain
//   empty       registered empty flag
module fifo_read_scheduler #(
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic              r_clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic              flush,
    input  logic [ADDR_W:0]   w_ptr_gray,
    output logic [ADDR_W-1:0] r_addr,
    output logic              rd_en,
    output logic [N_REQ-1:0]  gnt,
    output logic [N_REQ-1:0]  rvalid,
    output logic [ADDR_W:0]   r_ptr_gray,
    output logic              empty
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t           state;
    logic [ADDR_W:0]  r_bin;
    logic [ADDR_W:0]  r_bin_next;
    logic [ADDR_W:0]  r_gray_next;
    logic [ADDR_W:0]  wq1;
    logic [ADDR_W:0]  wq2;
    logic [IDX_W-1:0] prio;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_pick;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] grant_idx;
    logic             rr_found;
    logic [CNT_W-1:0] cnt;
    logic             burst_release;

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b = g;
        for (int unsigned i = ADDR_W; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

    // Round-robin search: first requester at or after prio, wrapping.
    always_comb begin
        rr_pick  = '0;
        rr_found = 1'b0;
        scan_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_idx = IDX_W'((32'(prio) + i) % N_REQ);
            if (!rr_found && req[scan_idx]) begin
                rr_found = 1'b1;
                rr_pick  = scan_idx;
            end
        end
    end

    // The owner gives up the port when it stops requesting or has used its
    // whole burst; that cycle is the single bubble between owners.
    assign burst_release = (state == BURST) && (!req[owner] || (cnt >= CNT_MAX));

    always_comb begin
        rd_en     = 1'b0;
        grant_idx = owner;
        gnt       = '0;
        if (!flush && !empty) begin
            if (state == IDLE) begin
                if (rr_found) begin
                    rd_en     = 1'b1;
                    grant_idx = rr_pick;
                end
            end else if (!burst_release) begin
                rd_en = 1'b1;
            end
        end
        if (rd_en) begin
            gnt[grant_idx] = 1'b1;
        end
    end

    assign r_addr      = r_bin[ADDR_W-1:0];
    assign r_bin_next  = r_bin + {{ADDR_W{1'b0}}, rd_en};
    assign r_gray_next = r_bin_next ^ (r_bin_next >> 1);

    always_ff @(posedge r_clk or negedge rst) begin
        if (!rst) begin
            wq1        <= '0;
            wq2        <= '0;
            r_bin      <= '0;
            r_ptr_gray <= '0;
            empty      <= 1'b1;
            state      <= IDLE;
            prio       <= '0;
            owner      <= '0;
            cnt        <= '0;
            rvalid     <= '0;
        end else begin
            wq1    <= w_ptr_gray;
            wq2    <= wq1;
            // gnt is forced low during flush, so this also clears rvalid after it
            rvalid <= gnt;
            if (flush) begin
                // Jump the read pointer onto the synchronised write pointer.
                r_bin      <= gray2bin(wq2);
                r_ptr_gray <= wq2;
                empty      <= 1'b1;
                state      <= IDLE;
                cnt        <= '0;
            end else begin
                r_bin      <= r_bin_next;
                r_ptr_gray <= r_gray_next;
                empty      <= (r_gray_next == wq2);
                unique case (state)
                    IDLE: begin
                        if (rd_en) begin
                            owner <= rr_pick;
                            cnt   <= CNT_W'(1);
                            state <= BURST;
                        end
                    end
                    BURST: begin
                        if (burst_release) begin
                            prio  <= IDX_W'((32'(owner) + 1) % N_REQ);
                            state <= IDLE;
                        end else if (rd_en) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_read_scheduler.sv
// tb_fifo_read_scheduler
//   Bench for fifo_read_scheduler. Acts as the write side (memory contents
//   plus Gray write pointer) and as the consumers (each wants a number of
//   words and holds req until it has been granted that many). Every written
//   token is queued; the monitor pops one per read and compares it with the
//   memory word at r_addr, and checks the grant rules on every read.
module tb_fifo_read_scheduler;

    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned N_REQ     = 4;
    localparam int unsigned BURST_MAX = 4;
    localparam int unsigned DEPTH     = 1 << ADDR_W;

    logic              r_clk = 1'b0;
    logic              rst;
    logic [N_REQ-1:0]  req;
    logic              flush;
    logic [ADDR_W:0]   w_ptr_gray;
    logic [ADDR_W-1:0] r_addr;
    logic              rd_en;
    logic [N_REQ-1:0]  gnt;
    logic [N_REQ-1:0]  rvalid;
    logic [ADDR_W:0]   r_ptr_gray;
    logic              empty;

    fifo_read_scheduler #(
        .ADDR_W   (ADDR_W),
        .N_REQ    (N_REQ),
        .BURST_MAX(BURST_MAX)
    ) dut (
        .r_clk     (r_clk),
        .rst       (rst),
        .req       (req),
        .flush     (flush),
        .w_ptr_gray(w_ptr_gray),
        .r_addr    (r_addr),
        .rd_en     (rd_en),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .r_ptr_gray(r_ptr_gray),
        .empty     (empty)
    );

    always #5 r_clk = ~r_clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // write-side / consumer model
    logic [7:0]       mem [DEPTH];
    logic [7:0]       expq [$];
    logic [ADDR_W:0]  w_bin;
    logic [7:0]       tok_ctr = 8'h00;
    int               pending [N_REQ];
    logic [N_REQ-1:0] g_seen;

    // read log kept by the monitor
    int               glog_idx  [$];
    int unsigned      glog_cyc  [$];
    logic [ADDR_W-1:0] glog_addr [$];
    logic [ADDR_W:0]  glog_gray [$];

    // monitor state
    int unsigned      cyc = 0;
    int               last_idx = -1;
    int               run_len = 0;
    int               idx;
    logic [N_REQ-1:0] prev_gnt = '0;

    int e2_idx [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int e2_off [8] = '{0, 1, 2, 3, 5, 6, 7, 8};
    int e4_idx [6] = '{0, 0, 2, 2, 2, 2};
    int e4_off [6] = '{0, 1, 3, 4, 5, 6};
    int e3_addr [4] = '{6, 7, 0, 1};
    int e3_gray [4] = '{9, 8, 0, 1};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic update_req();
        for (int i = 0; i < N_REQ; i++) req[i] = (pending[i] > 0);
    endtask

    task automatic write_word();
        mem[w_bin[ADDR_W-1:0]] = tok_ctr;
        expq.push_back(tok_ctr);
        tok_ctr    = tok_ctr + 8'd1;
        w_bin      = w_bin + 1'b1;
        w_ptr_gray = w_bin ^ (w_bin >> 1);
    endtask

    // advance one clock; consumers account for grants seen before the edge
    task automatic step();
        @(posedge r_clk);
        #1;
        for (int i = 0; i < N_REQ; i++)
            if (g_seen[i] && pending[i] > 0) pending[i]--;
        update_req();
    endtask

    task automatic peek();
        @(negedge r_clk);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        flush      = 1'b0;
        req        = '0;
        w_bin      = '0;
        w_ptr_gray = '0;
        expq.delete();
        for (int i = 0; i < N_REQ; i++) pending[i] = 0;
        glog_idx.delete();
        glog_cyc.delete();
        glog_addr.delete();
        glog_gray.delete();
        @(posedge r_clk);
        @(posedge r_clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int k = 0;
        while (glog_idx.size() < n && k < budget) begin
            step();
            k++;
        end
        check({"wait_", name}, 32'(glog_idx.size() >= n), 1);
    endtask

    task automatic feed(input int n, input int cons, input int budget);
        int written = 0;
        int k = 0;
        pending[cons] += n;
        update_req();
        while (!(written == n && pending[cons] == 0) && k < budget) begin
            if (written < n && expq.size() < DEPTH) begin
                write_word();
                written++;
            end
            step();
            k++;
        end
        check("feed_done", 32'(written == n && pending[cons] == 0), 1);
        repeat (2) step();
    endtask

    // scoreboard / rule monitor
    always @(negedge r_clk) begin
        cyc++;
        if (!rst) begin
            prev_gnt = '0;
            last_idx = -1;
            run_len  = 0;
            g_seen   = '0;
        end else begin
            g_seen = gnt;
            check("rvalid", 32'(rvalid), 32'(prev_gnt));
            if (rd_en || (gnt != '0)) begin
                idx = -1;
                for (int i = 0; i < N_REQ; i++) if (gnt[i]) idx = i;
                check("gnt_onehot_req",
                      32'(rd_en && $onehot(gnt) && ((gnt & ~req) == '0)), 1);
                run_len = (idx == last_idx) ? run_len + 1 : 1;
                check("burst_len", 32'(run_len <= BURST_MAX), 1);
                check("handover_bubble", 32'(last_idx < 0 || idx == last_idx), 1);
                n_tests++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL read_when_empty: rd_en=1 at r_addr %0d, required no read", r_addr);
                end else begin
                    logic [7:0] exp_tok;
                    exp_tok = expq.pop_front();
                    if (mem[r_addr] !== exp_tok) begin
                        n_fail++;
                        $display("FAIL read_data: word %0h at r_addr %0d, required %0h",
                                 mem[r_addr], r_addr, exp_tok);
                    end
                end
                glog_idx.push_back(idx);
                glog_cyc.push_back(cyc);
                glog_addr.push_back(r_addr);
                glog_gray.push_back(r_ptr_gray);
                last_idx = idx;
            end else begin
                last_idx = -1;
                run_len  = 0;
            end
            prev_gnt = gnt;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet;
        int sum;
        int k;
        req        = '0;
        flush      = 1'b0;
        w_ptr_gray = '0;
        w_bin      = '0;
        rst        = 1'b0;

        // reset state
        do_reset();
        check("rst_empty", 32'(empty), 1);
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_r_ptr_gray", 32'(r_ptr_gray), 0);
        check("rst_r_addr", 32'(r_addr), 0);
        check("rst_rvalid", 32'(rvalid), 0);

        // 1: two words, single consumer, empty latency
        write_word();
        write_word();
        pending[0] = 2;
        update_req();
        check("t1_w_ptr", 32'(w_ptr_gray), 32'h3);
        peek(); check("t1_empty_c0", 32'(empty), 1);
        step(); peek(); check("t1_empty_c1", 32'(empty), 1);
        step(); peek(); check("t1_empty_c2", 32'(empty), 1);
        step(); peek();
        check("t1_empty_c3", 32'(empty), 0);
        check("t1_rd0", 32'(rd_en), 1);
        check("t1_addr0", 32'(r_addr), 0);
        check("t1_gnt0", 32'(gnt), 32'h1);
        step(); peek();
        check("t1_rd1", 32'(rd_en), 1);
        check("t1_addr1", 32'(r_addr), 1);
        check("t1_rvalid0", 32'(rvalid), 32'h1);
        step(); peek();
        check("t1_empty_end", 32'(empty), 1);
        check("t1_rd_end", 32'(rd_en), 0);
        check("t1_r_ptr_gray", 32'(r_ptr_gray), 32'h3);
        check("t1_rvalid1", 32'(rvalid), 32'h1);

        // 2: eight words, all requesting: 4 to req0, bubble, 4 to req1
        do_reset();
        repeat (8) write_word();
        for (int i = 0; i < N_REQ; i++) pending[i] = 8;
        update_req();
        wait_log(8, 60, "t2");
        if (glog_idx.size() >= 8) begin
            for (int j = 0; j < 8; j++) begin
                check("t2_owner", 32'(glog_idx[j]), 32'(e2_idx[j]));
                check("t2_slot", glog_cyc[j] - glog_cyc[0], 32'(e2_off[j]));
            end
        end
        write_word();
        wait_log(9, 20, "t2_prio");
        if (glog_idx.size() >= 9) check("t2_next_owner", 32'(glog_idx[8]), 2);

        // 3: pointer wrap after 14 reads
        do_reset();
        feed(14, 0, 200);
        check("t3_reads", 32'(glog_idx.size()), 14);
        feed(4, 0, 60);
        if (glog_idx.size() >= 18) begin
            for (int j = 0; j < 4; j++) begin
                check("t3_addr", 32'(glog_addr[14+j]), 32'(e3_addr[j]));
                check("t3_gray", 32'(glog_gray[14+j]), 32'(e3_gray[j]));
            end
        end

        // 4: owner drops req mid-burst, pending requester takes over
        do_reset();
        repeat (6) write_word();
        pending[0] = 2;
        pending[2] = 4;
        update_req();
        wait_log(6, 40, "t4");
        if (glog_idx.size() >= 6) begin
            for (int j = 0; j < 6; j++) begin
                check("t4_owner", 32'(glog_idx[j]), 32'(e4_idx[j]));
                check("t4_slot", glog_cyc[j] - glog_cyc[0], 32'(e4_off[j]));
            end
        end

        // 5: flush in the middle of a burst with 5 words unread
        do_reset();
        repeat (7) write_word();
        pending[0] = 20;
        update_req();
        wait_log(2, 30, "t5");
        flush = 1'b1;
        peek();
        check("t5_flush_rd_en", 32'(rd_en), 0);
        check("t5_flush_gnt", 32'(gnt), 0);
        step();
        flush = 1'b0;
        expq.delete();
        peek();
        check("t5_empty", 32'(empty), 1);
        check("t5_r_ptr_gray", 32'(r_ptr_gray), 32'h4);
        repeat (6) begin
            step(); peek();
            check("t5_no_grant", 32'(rd_en), 0);
        end
        check("t5_reads", 32'(glog_idx.size()), 2);
        write_word();
        wait_log(3, 20, "t5_new");
        if (glog_addr.size() >= 3) check("t5_new_addr", 32'(glog_addr[2]), 7);

        // 6: asynchronous reset during a burst
        do_reset();
        repeat (6) write_word();
        pending[0] = 10;
        update_req();
        wait_log(2, 30, "t6");
        check("t6_pre_rd_en", 32'(rd_en), 1);
        #1;
        rst = 1'b0;
        #1;
        check("t6_gnt", 32'(gnt), 0);
        check("t6_rd_en", 32'(rd_en), 0);
        check("t6_rvalid", 32'(rvalid), 0);
        check("t6_empty", 32'(empty), 1);
        check("t6_r_ptr_gray", 32'(r_ptr_gray), 0);
        check("t6_r_addr", 32'(r_addr), 0);

        // randomized traffic with occasional flushes
        do_reset();
        quiet = 0;
        for (int unsigned c = 0; c < 3000; c++) begin
            if (quiet > 0) begin
                quiet--;
                if (quiet == 0) flush = 1'b1;
            end else begin
                if ($urandom_range(0, 99) < 40 && expq.size() < DEPTH) write_word();
                if ($urandom_range(0, 249) == 0) quiet = 4;
            end
            for (int i = 0; i < N_REQ; i++)
                if (pending[i] == 0 && $urandom_range(0, 99) < 10)
                    pending[i] = int'($urandom_range(1, 6));
            update_req();
            step();
            if (flush) begin
                flush = 1'b0;
                expq.delete();
            end
        end

        // drain: supply exactly enough words for the outstanding demand
        k = 0;
        sum = 0;
        for (int i = 0; i < N_REQ; i++) sum += pending[i];
        while (sum > 0 && k < 500) begin
            if (expq.size() < DEPTH && sum > expq.size()) write_word();
            step();
            k++;
            sum = 0;
            for (int i = 0; i < N_REQ; i++) sum += pending[i];
        end
        check("drain_all_served", 32'(sum == 0), 1);
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
